fetch_unit: RTL and testbench



---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 63 ++++++
 rtl/fetch_unit.sv | 165 ++++++++++++++++
 tb/tb_fetch_unit.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths, reset PC, state and buffer entry types for the fetch stage
package fetch_pkg;

    localparam int                          DEFAULT_PC_WIDTH    = 16;
    localparam int                          DEFAULT_INSTR_WIDTH = 16;
    localparam logic [DEFAULT_PC_WIDTH-1:0] DEFAULT_RESET_PC    = 16'h0000;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [DEFAULT_PC_WIDTH-1:0]    pc;
        logic [DEFAULT_INSTR_WIDTH-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous fetch buffer with push, pop, flush, count and head output
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       push_data_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output logic [$clog2(DEPTH):0] count_o,
    output logic [WIDTH-1:0]       head_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Depth is a power of two, so pointers wrap by natural overflow.
            if (push_i) begin
                mem_d[wr_ptr_q] = push_data_i;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (pop_i) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage; FETCH_PERF_CNT_EN adds fetched/flush counters
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                  PC_WIDTH    = DEFAULT_PC_WIDTH,
    parameter int                  INSTR_WIDTH = DEFAULT_INSTR_WIDTH,
    parameter int                  FIFO_DEPTH  = 2,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = PC_WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic                   clk_pi,
    input  logic                   reset_pi,
    output logic                   imem_req_po,
    output logic [PC_WIDTH-1:0]    imem_addr_po,
    input  logic                   imem_rvalid_pi,
    input  logic [INSTR_WIDTH-1:0] imem_rdata_pi,
    output logic                   instr_valid_po,
    output logic [INSTR_WIDTH-1:0] instruction_po,
    output logic [PC_WIDTH-1:0]    instr_pc_po,
    input  logic                   instr_ready_pi,
    input  logic                   redirect_pi,
    input  logic [PC_WIDTH-1:0]    redirect_pc_pi,
    input  logic                   rst_cmd_pi,
    input  logic                   halt_pi,
    output logic                   halted_po
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]            fetched_cnt_po,
    output logic [15:0]            flush_cnt_po
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int ENT_W = PC_WIDTH + INSTR_WIDTH;

    fetch_state_e        state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [PC_WIDTH-1:0] req_pc_q, req_pc_d;
    logic                outstanding_q, outstanding_d;
    logic                drop_q, drop_d;

    logic                issue, fifo_push, fifo_pop, fifo_flush;
    logic                accept, resp_push, can_issue, in_flight_lost;
    logic [CNT_W-1:0]    fifo_count;
    logic [CNT_W:0]      occupancy_next;
    logic [ENT_W-1:0]    fifo_head;

    assign accept         = instr_valid_po & instr_ready_pi;
    assign resp_push      = imem_rvalid_pi & ~drop_q;
    assign occupancy_next = {1'b0, fifo_count} + (CNT_W+1)'(resp_push) - (CNT_W+1)'(accept);
    assign can_issue      = (~outstanding_q | imem_rvalid_pi) &&
                            (occupancy_next < (CNT_W+1)'(FIFO_DEPTH));
    // A flush while a request is in flight must swallow its late response.
    assign in_flight_lost = outstanding_q & ~imem_rvalid_pi;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        req_pc_d      = req_pc_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        issue         = 1'b0;
        fifo_push     = 1'b0;
        fifo_pop      = 1'b0;
        fifo_flush    = 1'b0;
        if (imem_rvalid_pi) begin
            outstanding_d = 1'b0;
            drop_d        = 1'b0;
        end
        if (reset_pi) begin
            fifo_flush = 1'b1;
        end else if (rst_cmd_pi) begin
            fifo_flush = 1'b1;
            pc_d       = RESET_PC;
            state_d    = RUN;
            if (in_flight_lost) drop_d = 1'b1;
        end else if (state_q == RUN) begin
            if (halt_pi) begin
                fifo_flush = 1'b1;
                state_d    = HALTED;
                if (in_flight_lost) drop_d = 1'b1;
            end else if (redirect_pi) begin
                fifo_flush = 1'b1;
                pc_d       = redirect_pc_pi;
                if (in_flight_lost) drop_d = 1'b1;
            end else begin
                fifo_push = resp_push;
                fifo_pop  = accept;
                if (can_issue) begin
                    issue         = 1'b1;
                    req_pc_d      = pc_q;
                    pc_d          = pc_q + PC_WIDTH'(1);
                    outstanding_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_pi) begin
        if (reset_pi) begin
            state_q       <= RUN;
            pc_q          <= RESET_PC;
            req_pc_q      <= RESET_PC;
            outstanding_q <= 1'b0;
            drop_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            req_pc_q      <= req_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

    fetch_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk_pi),
        .reset_i     (reset_pi),
        .push_i      (fifo_push),
        .push_data_i ({req_pc_q, imem_rdata_pi}),
        .pop_i       (fifo_pop),
        .flush_i     (fifo_flush),
        .count_o     (fifo_count),
        .head_o      (fifo_head)
    );

    assign imem_req_po    = issue;
    assign imem_addr_po   = pc_q;
    assign instr_valid_po = (fifo_count != '0);
    assign instruction_po = fifo_head[INSTR_WIDTH-1:0];
    assign instr_pc_po    = fifo_head[ENT_W-1:INSTR_WIDTH];
    assign halted_po      = (state_q == HALTED);

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] fetched_cnt_q, fetched_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;
    logic        flush_discard;

    // Only flushes that actually throw work away are counted.
    assign flush_discard = fifo_flush & ~reset_pi &
                           ((fifo_count != '0) | (outstanding_q & ~drop_q));

    always_comb begin
        fetched_cnt_d = fetched_cnt_q;
        flush_cnt_d   = flush_cnt_q;
        if (fifo_pop && fetched_cnt_q != 16'hFFFF) fetched_cnt_d = fetched_cnt_q + 16'd1;
        if (flush_discard && flush_cnt_q != 16'hFFFF) flush_cnt_d = flush_cnt_q + 16'd1;
    end

    always_ff @(posedge clk_pi) begin
        if (reset_pi) begin
            fetched_cnt_q <= '0;
            flush_cnt_q   <= '0;
        end else begin
            fetched_cnt_q <= fetched_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
        end
    end

    assign fetched_cnt_po = fetched_cnt_q;
    assign flush_cnt_po   = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed scoreboard bench for fetch_unit (FETCH_PERF_CNT_EN aware)
module tb_fetch_unit;

    logic        clk_pi = 1'b0;
    logic        reset_pi = 1'b1;
    logic        imem_req_po;
    logic [15:0] imem_addr_po;
    logic        imem_rvalid_pi = 1'b0;
    logic [15:0] imem_rdata_pi = 16'h0000;
    logic        instr_valid_po;
    logic [15:0] instruction_po;
    logic [15:0] instr_pc_po;
    logic        instr_ready_pi = 1'b0;
    logic        redirect_pi = 1'b0;
    logic [15:0] redirect_pc_pi = 16'h0000;
    logic        rst_cmd_pi = 1'b0;
    logic        halt_pi = 1'b0;
    logic        halted_po;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] fetched_cnt_po;
    logic [15:0] flush_cnt_po;
    logic [15:0] flush_before;
`endif

    always #5 clk_pi = ~clk_pi;

    fetch_unit dut (
        .clk_pi         (clk_pi),
        .reset_pi       (reset_pi),
        .imem_req_po    (imem_req_po),
        .imem_addr_po   (imem_addr_po),
        .imem_rvalid_pi (imem_rvalid_pi),
        .imem_rdata_pi  (imem_rdata_pi),
        .instr_valid_po (instr_valid_po),
        .instruction_po (instruction_po),
        .instr_pc_po    (instr_pc_po),
        .instr_ready_pi (instr_ready_pi),
        .redirect_pi    (redirect_pi),
        .redirect_pc_pi (redirect_pc_pi),
        .rst_cmd_pi     (rst_cmd_pi),
        .halt_pi        (halt_pi),
        .halted_po      (halted_po)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetched_cnt_po (fetched_cnt_po),
        .flush_cnt_po   (flush_cnt_po)
`endif
    );

    int          checks = 0;
    int          errors = 0;
    int          pops = 0;
    int          mem_lat = 1;
    logic        mem_busy = 1'b0;
    int          mem_cnt = 0;
    logic [15:0] mem_addr = 16'h0000;
    logic [15:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic fill(input logic [15:0] base);
        logic [15:0] v;
        v = base;
        exp_q.delete();
        for (int i = 0; i < 48; i++) begin
            exp_q.push_back(v);
            v = v + 16'd1;
        end
    endtask

    // Instruction memory: word = address + 16'h1000, fixed latency per request.
    initial begin
        forever begin
            @(posedge clk_pi);
            #1;
            if (mem_busy && mem_cnt <= 1) begin
                imem_rvalid_pi = 1'b1;
                imem_rdata_pi  = mem_addr + 16'h1000;
                mem_busy       = 1'b0;
            end else begin
                imem_rvalid_pi = 1'b0;
                if (mem_busy) mem_cnt--;
            end
            @(negedge clk_pi);
            if (reset_pi) begin
                mem_busy = 1'b0;
            end else if (imem_req_po) begin
                mem_busy = 1'b1;
                mem_cnt  = mem_lat;
                mem_addr = imem_addr_po;
            end
        end
    end

    // Decode side: every accepted word must match the next expected PC.
    initial begin
        logic [15:0] e;
        logic [15:0] ei;
        forever begin
            @(negedge clk_pi);
            if (!reset_pi && !redirect_pi && !rst_cmd_pi && !halt_pi &&
                instr_valid_po && instr_ready_pi) begin
                check("pop_expected_available", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e  = exp_q.pop_front();
                    ei = e + 16'h1000;
                    check("pop_pc", instr_pc_po, e);
                    check("pop_instr", instruction_po, ei);
                end
                pops++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        found;
        logic [15:0] next_addr;
        logic [15:0] head_pc;
        logic [15:0] head_instr;
        int          cnt;
        int          p0;

        repeat (3) @(posedge clk_pi);
        @(negedge clk_pi);
        check("rst_req", imem_req_po, 0);
        check("rst_addr", imem_addr_po, 16'h0000);
        check("rst_valid", instr_valid_po, 0);
        check("rst_instr", instruction_po, 16'h0000);
        check("rst_pc", instr_pc_po, 16'h0000);
        check("rst_halted", halted_po, 0);

        fill(16'h0000);
        @(posedge clk_pi); #1;
        reset_pi = 1'b0;
        instr_ready_pi = 1'b1;
        @(negedge clk_pi);
        check("first_req", imem_req_po, 1);
        check("first_addr", imem_addr_po, 16'h0000);
        @(negedge clk_pi);
        check("second_req", imem_req_po, 1);
        check("second_addr", imem_addr_po, 16'h0001);
        @(negedge clk_pi);
        check("head0_valid", instr_valid_po, 1);
        check("head0_pc", instr_pc_po, 16'h0000);
        check("head0_instr", instruction_po, 16'h1000);
        @(negedge clk_pi);
        check("head1_valid", instr_valid_po, 1);
        check("head1_pc", instr_pc_po, 16'h0001);
        check("head1_instr", instruction_po, 16'h1001);
        repeat (4) @(negedge clk_pi);

        // Decode stall: buffer fills, requests stop, head holds.
        @(posedge clk_pi); #1;
        instr_ready_pi = 1'b0;
        head_pc    = exp_q[0];
        head_instr = head_pc + 16'h1000;
        cnt = 0;
        repeat (6) begin
            @(negedge clk_pi);
            if (imem_req_po) cnt++;
        end
        check("stall_no_req", cnt, 0);
        check("stall_valid", instr_valid_po, 1);
        check("stall_head_pc", instr_pc_po, head_pc);
        check("stall_head_instr", instruction_po, head_instr);
        mem_lat = 3;
        @(posedge clk_pi); #1;
        instr_ready_pi = 1'b1;
        repeat (8) @(negedge clk_pi);

        // Redirect while the request to 0x0005 is in flight.
        @(posedge clk_pi); #1;
        redirect_pi = 1'b1;
        redirect_pc_pi = 16'h0005;
        fill(16'h0040);
        @(posedge clk_pi); #1;
        redirect_pi = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk_pi);
            if (imem_req_po && imem_addr_po === 16'h0005) found = 1'b1;
        end
        check("req_0005_seen", found, 1);
        @(posedge clk_pi); #1;
        redirect_pi = 1'b1;
        redirect_pc_pi = 16'h0040;
        @(negedge clk_pi);
        check("redirect_no_req", imem_req_po, 0);
        p0 = pops;
        @(posedge clk_pi); #1;
        redirect_pi = 1'b0;
        repeat (16) @(negedge clk_pi);
        check("redirect_delivered", 32'(pops > p0), 32'd1);

        // PC wrap from 0xFFFF to 0x0000.
        @(posedge clk_pi); #1;
        mem_lat = 1;
        redirect_pi = 1'b1;
        redirect_pc_pi = 16'hFFFE;
        fill(16'hFFFE);
        @(posedge clk_pi); #1;
        redirect_pi = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk_pi);
            if (imem_req_po && imem_addr_po === 16'hFFFF) found = 1'b1;
        end
        check("req_ffff_seen", found, 1);
        found = 1'b0;
        next_addr = 16'hDEAD;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk_pi);
            if (imem_req_po) begin
                found = 1'b1;
                next_addr = imem_addr_po;
            end
        end
        check("wrap_req_seen", found, 1);
        check("wrap_addr", next_addr, 16'h0000);
        p0 = pops;
        repeat (8) @(negedge clk_pi);
        check("wrap_delivered", 32'(pops > p0), 32'd1);

        // Halt with a full buffer; redirect while halted is ignored.
        @(posedge clk_pi); #1;
        instr_ready_pi = 1'b0;
        repeat (4) @(negedge clk_pi);
        check("pre_halt_valid", instr_valid_po, 1);
        @(posedge clk_pi); #1;
        halt_pi = 1'b1;
        @(posedge clk_pi); #1;
        halt_pi = 1'b0;
        @(negedge clk_pi);
        check("halt_valid", instr_valid_po, 0);
        check("halt_halted", halted_po, 1);
        @(posedge clk_pi); #1;
        redirect_pi = 1'b1;
        redirect_pc_pi = 16'h0080;
        @(posedge clk_pi); #1;
        redirect_pi = 1'b0;
        cnt = 0;
        repeat (20) begin
            @(negedge clk_pi);
            if (imem_req_po) cnt++;
        end
        check("halt_no_req", cnt, 0);
        check("halt_still_halted", halted_po, 1);
        check("halt_still_invalid", instr_valid_po, 0);

        // Hard reset restarts fetch at 0x0000.
        @(posedge clk_pi); #1;
        reset_pi = 1'b1;
        pops = 0;
        fill(16'h0000);
        @(posedge clk_pi); #1;
        reset_pi = 1'b0;
        instr_ready_pi = 1'b1;
        @(negedge clk_pi);
        check("restart_req", imem_req_po, 1);
        check("restart_addr", imem_addr_po, 16'h0000);
        check("restart_halted", halted_po, 0);
        repeat (5) @(negedge clk_pi);

        // Soft reset wins over a simultaneous redirect.
`ifdef FETCH_PERF_CNT_EN
        flush_before = flush_cnt_po + 16'd1;
`endif
        @(posedge clk_pi); #1;
        rst_cmd_pi = 1'b1;
        redirect_pi = 1'b1;
        redirect_pc_pi = 16'h0080;
        fill(16'h0000);
        @(negedge clk_pi);
        check("rstcmd_no_req", imem_req_po, 0);
        p0 = pops;
        @(posedge clk_pi); #1;
        rst_cmd_pi = 1'b0;
        redirect_pi = 1'b0;
        @(negedge clk_pi);
        check("rstcmd_req", imem_req_po, 1);
        check("rstcmd_addr", imem_addr_po, 16'h0000);
`ifdef FETCH_PERF_CNT_EN
        check("flush_cnt_inc", flush_cnt_po, flush_before);
`endif
        repeat (6) @(negedge clk_pi);
        check("rstcmd_delivered", 32'(pops > p0), 32'd1);
        @(posedge clk_pi); #1;
        instr_ready_pi = 1'b0;
        repeat (2) @(negedge clk_pi);
`ifdef FETCH_PERF_CNT_EN
        check("fetched_cnt", fetched_cnt_po, 16'(pops));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
